// File: rtl/dist_ram_pkg.sv
// rtl/dist_ram_pkg.sv - shared types and constants for the multi-read-port distributed RAM
package dist_ram_pkg;

    // Sweep FSM: CLEAR writes INIT_VALUE to every word, IDLE serves user traffic.
    typedef enum logic {
        RAM_CLEAR,
        RAM_IDLE
    } ram_state_t;

    localparam int DIST_RAM_DEFAULT_DEPTH = 32;
    localparam int DIST_RAM_DEFAULT_LAST  = DIST_RAM_DEFAULT_DEPTH - 1;

    // Last address the clear sweep writes before returning to IDLE.
    function automatic int sweep_last_addr(input int depth);
        return depth - 1;
    endfunction

endpackage

// File: rtl/dist_ram_rd_port.sv
// rtl/dist_ram_rd_port.sv - one registered read port: range check, optional bypass, output/valid register
//
// Build option: DIST_RAM_BYPASS_EN (defined = write-first forwarding, undefined = read-first)
//
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   rd_en      read strobe, already blocked by the top while the sweep runs
//   rd_addr    read address
//   mem_word   array contents at rd_addr (old contents this cycle)
//   wr_en      effective user write this cycle
//   wr_addr    user write address
//   wr_data    user write data
//   data_out   registered read data, holds while rd_en is low
//   rd_valid   single-cycle pulse one cycle after rd_en
module dist_ram_rd_port #(
    parameter int DATA_WIDTH    = 8,
    parameter int DATA_DEPTH    = 32,
    parameter int ADDRESS_WIDTH = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rd_en,
    input  logic [ADDRESS_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0]    mem_word,
    input  logic                     wr_en,
    input  logic [ADDRESS_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0]    wr_data,
    output logic [DATA_WIDTH-1:0]    data_out,
    output logic                     rd_valid
);

    logic                  in_range;
    logic [DATA_WIDTH-1:0] rd_word;

    assign in_range = (32'(rd_addr) < DATA_DEPTH);

`ifdef DIST_RAM_BYPASS_EN
    // Write-first: a same-cycle write to the addressed word is forwarded.
    always_comb begin
        rd_word = mem_word;
        if (wr_en && (wr_addr == rd_addr)) begin
            rd_word = wr_data;
        end
    end
`else
    logic unused_wr;
    assign unused_wr = ^{wr_en, wr_addr, wr_data};
    assign rd_word   = mem_word;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                // Addresses past the end of the store read as zero.
                data_out <= in_range ? rd_word : '0;
            end
        end
    end

endmodule

// File: rtl/dist_ram_mp.sv
// rtl/dist_ram_mp.sv - distributed RAM, one write port, NUM_READ_PORTS registered read ports, clear sweep
//
// Build option: DIST_RAM_BYPASS_EN (read-during-write forwarding inside each read port)
//
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   init_req   start a clear sweep, honoured only in IDLE
//   busy       high while the clear sweep runs
//   write_en   write strobe; in_addr / data_in write address and data
//   rd_en      per-port read strobe
//   out_addr   packed read addresses, port i = slice i
//   data_out   packed registered read data
//   rd_valid   per-port valid, one cycle after rd_en
module dist_ram_mp
    import dist_ram_pkg::*;
#(
    parameter int                    DATA_WIDTH     = 8,
    parameter int                    DATA_DEPTH     = DIST_RAM_DEFAULT_DEPTH,
    parameter int                    ADDRESS_WIDTH  = $clog2(DATA_DEPTH),
    parameter int                    NUM_READ_PORTS = 2,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE     = '0
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     init_req,
    output logic                                     busy,
    input  logic                                     write_en,
    input  logic [ADDRESS_WIDTH-1:0]                 in_addr,
    input  logic [DATA_WIDTH-1:0]                    data_in,
    input  logic [NUM_READ_PORTS-1:0]                rd_en,
    input  logic [NUM_READ_PORTS*ADDRESS_WIDTH-1:0]  out_addr,
    output logic [NUM_READ_PORTS*DATA_WIDTH-1:0]     data_out,
    output logic [NUM_READ_PORTS-1:0]                rd_valid
);

    localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR =
        ADDRESS_WIDTH'(sweep_last_addr(DATA_DEPTH));

    logic [DATA_WIDTH-1:0]    mem [DATA_DEPTH];
    ram_state_t               state;
    logic [ADDRESS_WIDTH-1:0] sweep_cnt;
    logic                     user_we;

    assign busy = (state == RAM_CLEAR);

    // A user write lands only in IDLE, loses to a same-cycle init_req,
    // and is dropped when it points past the end of the store.
    assign user_we = write_en && !busy && !init_req &&
                     (32'(in_addr) < DATA_DEPTH);

    // Storage has no reset; the sweep is what gives it defined contents.
    always_ff @(posedge clk) begin
        if (busy) begin
            mem[sweep_cnt] <= INIT_VALUE;
        end else if (user_we) begin
            mem[in_addr] <= data_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RAM_CLEAR;
            sweep_cnt <= '0;
        end else begin
            case (state)
                RAM_CLEAR: begin
                    if (sweep_cnt == LAST_ADDR) begin
                        state     <= RAM_IDLE;
                        sweep_cnt <= '0;
                    end else begin
                        sweep_cnt <= sweep_cnt + 1'b1;
                    end
                end
                RAM_IDLE: begin
                    if (init_req) begin
                        state     <= RAM_CLEAR;
                        sweep_cnt <= '0;
                    end
                end
                default: begin
                    state     <= RAM_CLEAR;
                    sweep_cnt <= '0;
                end
            endcase
        end
    end

    for (genvar i = 0; i < NUM_READ_PORTS; i++) begin : g_rd
        logic [ADDRESS_WIDTH-1:0] addr_i;
        assign addr_i = out_addr[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];

        dist_ram_rd_port #(
            .DATA_WIDTH    (DATA_WIDTH),
            .DATA_DEPTH    (DATA_DEPTH),
            .ADDRESS_WIDTH (ADDRESS_WIDTH)
        ) u_rd_port (
            .clk      (clk),
            .rst      (rst),
            .rd_en    (rd_en[i] && !busy),
            .rd_addr  (addr_i),
            .mem_word (mem[addr_i]),
            .wr_en    (user_we),
            .wr_addr  (in_addr),
            .wr_data  (data_in),
            .data_out (data_out[i*DATA_WIDTH +: DATA_WIDTH]),
            .rd_valid (rd_valid[i])
        );
    end

endmodule

// File: tb/tb_dist_ram_mp.sv
// tb/tb_dist_ram_mp.sv - directed self-checking bench for dist_ram_mp (depth 32 and depth 24 instances)
module tb_dist_ram_mp;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        init_req = 1'b0;
    logic        busy;
    logic        write_en = 1'b0;
    logic [4:0]  in_addr  = '0;
    logic [7:0]  data_in  = '0;
    logic [1:0]  rd_en    = '0;
    logic [9:0]  out_addr = '0;
    logic [15:0] data_out;
    logic [1:0]  rd_valid;

    logic        init_req2 = 1'b0;
    logic        busy2;
    logic        write_en2 = 1'b0;
    logic [4:0]  in_addr2  = '0;
    logic [7:0]  data_in2  = '0;
    logic [1:0]  rd_en2    = '0;
    logic [9:0]  out_addr2 = '0;
    logic [15:0] data_out2;
    logic [1:0]  rd_valid2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    dist_ram_mp dut (
        .clk      (clk),
        .rst      (rst),
        .init_req (init_req),
        .busy     (busy),
        .write_en (write_en),
        .in_addr  (in_addr),
        .data_in  (data_in),
        .rd_en    (rd_en),
        .out_addr (out_addr),
        .data_out (data_out),
        .rd_valid (rd_valid)
    );

    dist_ram_mp #(.DATA_DEPTH(24)) dut24 (
        .clk      (clk),
        .rst      (rst),
        .init_req (init_req2),
        .busy     (busy2),
        .write_en (write_en2),
        .in_addr  (in_addr2),
        .data_in  (data_in2),
        .rd_en    (rd_en2),
        .out_addr (out_addr2),
        .data_out (data_out2),
        .rd_valid (rd_valid2)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One clock of stimulus on the depth-32 instance; inputs return to idle afterwards.
    task automatic cycle(input logic we, input logic [4:0] wa, input logic [7:0] wd,
                         input logic [1:0] re, input logic [4:0] a0, input logic [4:0] a1,
                         input logic ireq);
        write_en = we;
        in_addr  = wa;
        data_in  = wd;
        rd_en    = re;
        out_addr = {a1, a0};
        init_req = ireq;
        tick();
        write_en = 1'b0;
        rd_en    = '0;
        init_req = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int n2;
        int vflag;
        logic [7:0] exp_rdw;

        // Reset state
        tick();
        tick();
        check("rst_busy", busy, 1);
        check("rst_valid", rd_valid, 0);
        check("rst_dout", data_out, 0);

        // 1. Sweep length after reset release
        rst = 1'b0;
        n = 0;
        n2 = 0;
        while (busy && n < 100) begin
            if (busy2) n2++;
            tick();
            n++;
        end
        check("sweep_len32", n, 32);
        check("sweep_len24", n2, 24);
        check("busy24_done", busy2, 0);

        for (int a = 0; a < 32; a++) begin
            cycle(1'b0, 5'd0, 8'd0, 2'b11, 5'(a), 5'(31 - a), 1'b0);
            check("init_zero", data_out, 0);
            check("init_valid", rd_valid, 2'b11);
        end
        tick();
        check("valid_pulse", rd_valid, 0);

        // 2. Write then read, one-cycle latency and single-cycle valid
        cycle(1'b1, 5'd3, 8'hA5, 2'b00, 5'd0, 5'd0, 1'b0);
        check("wr_no_valid", rd_valid, 0);
        cycle(1'b0, 5'd0, 8'h00, 2'b01, 5'd3, 5'd0, 1'b0);
        check("rd3_data", data_out[7:0], 8'hA5);
        check("rd3_valid", rd_valid, 2'b01);
        tick();
        check("rd3_pulse", rd_valid, 0);
        check("rd3_hold", data_out[7:0], 8'hA5);

        // 3. Read during write to the same address
        cycle(1'b1, 5'd7, 8'h11, 2'b00, 5'd0, 5'd0, 1'b0);
        cycle(1'b1, 5'd7, 8'h5A, 2'b10, 5'd0, 5'd7, 1'b0);
`ifdef DIST_RAM_BYPASS_EN
        exp_rdw = 8'h5A;
`else
        exp_rdw = 8'h11;
`endif
        check("rdw_data", data_out[15:8], exp_rdw);
        check("rdw_valid", rd_valid, 2'b10);
        cycle(1'b0, 5'd0, 8'h00, 2'b10, 5'd0, 5'd7, 1'b0);
        check("rdw_after", data_out[15:8], 8'h5A);

        // 4. Both ports, different addresses, same cycle
        cycle(1'b1, 5'd7, 8'h11, 2'b00, 5'd0, 5'd0, 1'b0);
        cycle(1'b0, 5'd0, 8'h00, 2'b11, 5'd3, 5'd7, 1'b0);
        check("dual_data", data_out, 16'h11A5);
        check("dual_valid", rd_valid, 2'b11);

        // 6a. init_req: writes, reads and a second init_req during busy are ignored
        cycle(1'b0, 5'd0, 8'h00, 2'b00, 5'd0, 5'd0, 1'b1);
        check("init_busy", busy, 1);
        n = 0;
        vflag = 0;
        while (busy && n < 100) begin
            write_en = 1'b1;
            in_addr  = 5'd3;
            data_in  = 8'hFF;
            rd_en    = 2'b11;
            out_addr = {5'd3, 5'd3};
            init_req = (n == 10);
            tick();
            if (rd_valid != 2'b00) vflag = 1;
            n++;
        end
        write_en = 1'b0;
        rd_en    = '0;
        init_req = 1'b0;
        check("init_len", n, 32);
        check("busy_no_valid", vflag, 0);
        cycle(1'b0, 5'd0, 8'h00, 2'b11, 5'd3, 5'd7, 1'b0);
        check("init_cleared", data_out, 16'h0000);

        // init_req with write_en in the same IDLE cycle: the write is dropped
        cycle(1'b1, 5'd9, 8'h77, 2'b00, 5'd0, 5'd0, 1'b1);
        n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        check("init_wr_len", n, 32);
        cycle(1'b0, 5'd0, 8'h00, 2'b01, 5'd9, 5'd0, 1'b0);
        check("init_wr_drop", data_out[7:0], 8'h00);

        // 5. Reset mid-sweep restarts the sweep
        cycle(1'b1, 5'd20, 8'h33, 2'b00, 5'd0, 5'd0, 1'b0);
        cycle(1'b0, 5'd0, 8'h00, 2'b01, 5'd20, 5'd0, 1'b0);
        check("pre_rst_20", data_out[7:0], 8'h33);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        rst = 1'b1;
        #1;
        check("midrst_busy", busy, 1);
        check("midrst_dout", data_out, 0);
        tick();
        rst = 1'b0;
        n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        check("restart_len", n, 32);
        cycle(1'b0, 5'd0, 8'h00, 2'b10, 5'd0, 5'd20, 1'b0);
        check("restart_20", data_out[15:8], 8'h00);

        // 6b. Depth 24: out-of-range write discarded, out-of-range read returns 0 with valid
        n = 0;
        while (busy2 && n < 100) begin
            tick();
            n++;
        end
        check("d24_idle", busy2, 0);
        write_en2 = 1'b1;
        in_addr2  = 5'd23;
        data_in2  = 8'h42;
        tick();
        in_addr2  = 5'd30;
        data_in2  = 8'h99;
        tick();
        write_en2 = 1'b0;
        rd_en2    = 2'b11;
        out_addr2 = {5'd23, 5'd30};
        tick();
        rd_en2    = 2'b00;
        check("d24_oor_data", data_out2[7:0], 8'h00);
        check("d24_last_data", data_out2[15:8], 8'h42);
        check("d24_valid", rd_valid2, 2'b11);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
